// File: rtl/alu_cmd_ctrl.sv
// Command sequencer between the UART receiver/transmitter and the ALU stage.
// Optional frame/ALU timeout is enabled by defining ALU_CMD_TIMEOUT_EN.
module alu_cmd_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int OUT_WIDTH     = 2*DATA_WIDTH,
    parameter int FRAME_TIMEOUT = 1023
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic                  BUSY,
    output logic                  FRAME_ERR
);

    localparam logic [DATA_WIDTH-1:0] CMD_FULL  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_REUSE = DATA_WIDTH'(8'hDD);

    // The result is always returned as exactly two bytes.
    if (OUT_WIDTH != 2*DATA_WIDTH) begin : g_bad_out_width
        $error("alu_cmd_ctrl: OUT_WIDTH must equal 2*DATA_WIDTH");
    end
    if (FRAME_TIMEOUT < 1) begin : g_bad_timeout
        $error("alu_cmd_ctrl: FRAME_TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE, GET_A, GET_B, GET_FUN, ALU_REQ, ALU_WAIT, TX_LO, TX_HI
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [3:0]              alu_fun_q, alu_fun_d;
    logic [OUT_WIDTH-1:0]    res_q, res_d;
    logic                    frame_err_q, frame_err_d;

`ifdef ALU_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(FRAME_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;
    logic             cnt_active;

    assign timeout_hit = (cnt_q == CNT_W'(FRAME_TIMEOUT - 1));
    assign cnt_active  = (state_q == GET_A) || (state_q == GET_B) ||
                         (state_q == GET_FUN) || (state_q == ALU_WAIT);

    // Restart on any received byte and on every state change, so each waiting
    // state is timed from its own entry.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (RX_D_VLD || (state_d != state_q) || !cnt_active) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_fun_d   = alu_fun_q;
        res_d       = res_q;
        frame_err_d = 1'b0;
        ALU_EN      = 1'b0;
        TX_D_VLD    = 1'b0;
        TX_P_DATA   = '0;

        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_FULL) begin
                        state_d = GET_A;
                    end else if (RX_P_DATA == CMD_REUSE) begin
                        state_d = GET_FUN;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            GET_A: begin
                if (RX_D_VLD) begin
                    alu_a_d = RX_P_DATA;
                    state_d = GET_B;
                end
`ifdef ALU_CMD_TIMEOUT_EN
                else if (timeout_hit) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
`endif
            end
            GET_B: begin
                if (RX_D_VLD) begin
                    alu_b_d = RX_P_DATA;
                    state_d = GET_FUN;
                end
`ifdef ALU_CMD_TIMEOUT_EN
                else if (timeout_hit) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
`endif
            end
            GET_FUN: begin
                if (RX_D_VLD) begin
                    alu_fun_d = RX_P_DATA[3:0];
                    state_d   = ALU_REQ;
                end
`ifdef ALU_CMD_TIMEOUT_EN
                else if (timeout_hit) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
`endif
            end
            ALU_REQ: begin
                ALU_EN      = 1'b1;
                frame_err_d = RX_D_VLD;
                state_d     = ALU_WAIT;
            end
            ALU_WAIT: begin
                frame_err_d = RX_D_VLD;
                if (ALU_OUT_VLD) begin
                    res_d   = ALU_OUT;
                    state_d = TX_LO;
                end
`ifdef ALU_CMD_TIMEOUT_EN
                else if (timeout_hit) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
`endif
            end
            TX_LO: begin
                TX_D_VLD    = 1'b1;
                TX_P_DATA   = res_q[DATA_WIDTH-1:0];
                frame_err_d = RX_D_VLD;
                if (!TX_BUSY) begin
                    state_d = TX_HI;
                end
            end
            TX_HI: begin
                TX_D_VLD    = 1'b1;
                TX_P_DATA   = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                frame_err_d = RX_D_VLD;
                if (!TX_BUSY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= '0;
            res_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fun_q   <= alu_fun_d;
            res_q       <= res_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_FUN   = alu_fun_q;
    assign BUSY      = (state_q != IDLE);
    assign FRAME_ERR = frame_err_q;

endmodule
